// File: rtl/lexington_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : lexington
//  Purpose   : Shared constants and types for the interrupt controller
//              (source count, cause-number base, register map, FSM states).
//  Revision  : 1.0 - initial release
// ============================================================================
package lexington;

  localparam int NUM_IRQ_SRC = 16;
  localparam int IRQ_ID_BASE = 16;

  // Register map (3-bit index)
  localparam logic [2:0] IRQ_REG_ENABLE    = 3'd0;
  localparam logic [2:0] IRQ_REG_EDGE      = 3'd1;
  localparam logic [2:0] IRQ_REG_PRIO      = 3'd2;
  localparam logic [2:0] IRQ_REG_THRESH    = 3'd3;
  localparam logic [2:0] IRQ_REG_PENDING   = 3'd4;
  localparam logic [2:0] IRQ_REG_ACTIVE_ID = 3'd5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACTIVE = 2'd2
  } irq_state_t;

  // Index width for a given source count; never below one bit.
  function automatic int irq_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/irq_prio_sel.sv
`default_nettype none
// ============================================================================
//  Module    : irq_prio_sel
//  Purpose   : Combinational winner selection among eligible sources.
//              Highest 2-bit priority wins, ties resolve to the lowest index.
//              With all priorities tied to zero it degenerates into a plain
//              lowest-index-first picker.
//  Revision  : 1.0 - initial release
// ============================================================================
module irq_prio_sel
  import lexington::*;
#(
  parameter  int NUM_SRC = NUM_IRQ_SRC,
  localparam int IDX_W   = irq_idx_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0]   eligible,
  input  logic [2*NUM_SRC-1:0] prio,
  output logic                 valid,
  output logic [IDX_W-1:0]     idx
);

  logic [1:0] best_prio;

  // Linear scan: a later source only replaces the current pick on a strictly
  // higher priority, which gives lowest-index tie-breaking.
  always_comb begin
    valid     = 1'b0;
    idx       = '0;
    best_prio = 2'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (eligible[i] && (!valid || (prio[2*i +: 2] > best_prio))) begin
        valid     = 1'b1;
        idx       = IDX_W'(i);
        best_prio = prio[2*i +: 2];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module    : irq_ctrl
//  Purpose   : Interrupt controller. Latches edge/level requests, applies
//              enable, priority and threshold, offers one registered winner to
//              the trap unit with a req/ack/done handshake (no nesting).
//  Options   : IRQ_CTRL_PRIO_EN - implement PRIO and THRESH registers. When
//              undefined they read 0, eligibility is pending & ENABLE and the
//              lowest index wins.
//  Revision  : 1.0 - initial release
// ============================================================================
module irq_ctrl
  import lexington::*;
#(
  parameter int NUM_SRC = NUM_IRQ_SRC,
  parameter int ID_BASE = IRQ_ID_BASE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic               reg_rd_en,
  input  logic               reg_wr_en,
  input  logic [2:0]         reg_addr,
  input  logic [31:0]        reg_wr_data,
  output logic [31:0]        reg_rd_data,
  output logic               irq_req,
  output logic [4:0]         irq_id,
  input  logic               irq_ack,
  input  logic               irq_done,
  input  logic [4:0]         done_id,
  output logic               irq_active
);

  localparam int IDX_W = irq_idx_w(NUM_SRC);

  logic [NUM_SRC-1:0]   src_q, src_d;
  logic [NUM_SRC-1:0]   enable_q, enable_d;
  logic [NUM_SRC-1:0]   edge_q, edge_d;
  logic [NUM_SRC-1:0]   edge_pend_q, edge_pend_d;
  logic [IDX_W-1:0]     win_idx_q, win_idx_d;
  logic [4:0]           active_id_q, active_id_d;
  irq_state_t           state_q, state_d;

  logic [NUM_SRC-1:0]   pending;
  logic [NUM_SRC-1:0]   eligible;
  logic [NUM_SRC-1:0]   above_thresh;
  logic [NUM_SRC-1:0]   pend_clr;
  logic [2*NUM_SRC-1:0] sel_prio;
  logic                 sel_valid;
  logic [IDX_W-1:0]     sel_idx;
  logic [31:0]          prio_rd;
  logic [31:0]          thresh_rd;
  logic                 wr_pending;
  logic                 ack_take;
  logic                 done_take;
  logic                 unused_wr_data;

  // Not every write-data bit maps to storage in every build.
  assign unused_wr_data = ^reg_wr_data;

  assign wr_pending = reg_wr_en && (reg_addr == IRQ_REG_PENDING);
  assign ack_take   = irq_ack && (state_q == REQ);
  assign done_take  = irq_done && (state_q == ACTIVE) && (done_id == active_id_q);

  // Level sources follow the registered line; edge sources use the latch.
  assign pending  = (edge_q & edge_pend_q) | (~edge_q & src_q);
  assign eligible = pending & enable_q & above_thresh;

`ifdef IRQ_CTRL_PRIO_EN
  logic [2*NUM_SRC-1:0] prio_q, prio_d;
  logic [1:0]           thresh_q, thresh_d;

  // Priority/threshold register writes and per-source threshold compare.
  always_comb begin
    prio_d   = prio_q;
    thresh_d = thresh_q;
    if (reg_wr_en && (reg_addr == IRQ_REG_PRIO))   prio_d   = reg_wr_data[2*NUM_SRC-1:0];
    if (reg_wr_en && (reg_addr == IRQ_REG_THRESH)) thresh_d = reg_wr_data[1:0];
    above_thresh = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      above_thresh[i] = (prio_q[2*i +: 2] > thresh_q);
    end
    sel_prio  = prio_q;
    prio_rd   = 32'(prio_q);
    thresh_rd = {30'd0, thresh_q};
  end

  // Priority/threshold storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q   <= '0;
      thresh_q <= 2'd0;
    end else begin
      prio_q   <= prio_d;
      thresh_q <= thresh_d;
    end
  end
`else
  // No priority hardware: every enabled pending source qualifies equally.
  always_comb begin
    above_thresh = '1;
    sel_prio     = '0;
    prio_rd      = 32'd0;
    thresh_rd    = 32'd0;
  end
`endif

  irq_prio_sel #(
    .NUM_SRC (NUM_SRC)
  ) u_sel (
    .eligible (eligible),
    .prio     (sel_prio),
    .valid    (sel_valid),
    .idx      (sel_idx)
  );

  // Config writes and edge-pending update; a new edge beats any clear.
  always_comb begin
    src_d    = src_irq;
    enable_d = enable_q;
    edge_d   = edge_q;
    if (reg_wr_en) begin
      case (reg_addr)
        IRQ_REG_ENABLE: enable_d = reg_wr_data[NUM_SRC-1:0];
        IRQ_REG_EDGE:   edge_d   = reg_wr_data[NUM_SRC-1:0];
        default:        ;
      endcase
    end
    pend_clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      pend_clr[i] = (wr_pending && reg_wr_data[i]) ||
                    (ack_take && (win_idx_q == IDX_W'(i)));
    end
    edge_pend_d = edge_q & ((edge_pend_q & ~pend_clr) | (src_irq & ~src_q));
  end

  // Handshake state machine; the winner is re-registered every cycle so a
  // higher-priority arrival can replace the offer before it is acked.
  always_comb begin
    state_d     = state_q;
    active_id_d = active_id_q;
    win_idx_d   = sel_valid ? sel_idx : '0;
    case (state_q)
      IDLE: begin
        if (sel_valid) state_d = REQ;
      end
      REQ: begin
        if (irq_ack) begin
          state_d     = ACTIVE;
          active_id_d = irq_id;
        end else if (!sel_valid) begin
          state_d = IDLE;
        end
      end
      ACTIVE: begin
        if (done_take) begin
          state_d     = IDLE;
          active_id_d = 5'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All controller state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q       <= '0;
      enable_q    <= '0;
      edge_q      <= '0;
      edge_pend_q <= '0;
      win_idx_q   <= '0;
      active_id_q <= 5'd0;
      state_q     <= IDLE;
    end else begin
      src_q       <= src_d;
      enable_q    <= enable_d;
      edge_q      <= edge_d;
      edge_pend_q <= edge_pend_d;
      win_idx_q   <= win_idx_d;
      active_id_q <= active_id_d;
      state_q     <= state_d;
    end
  end

  assign irq_req    = (state_q == REQ);
  assign irq_active = (state_q == ACTIVE);
  assign irq_id     = irq_req ? 5'(ID_BASE + int'(win_idx_q)) : 5'd0;

  // Register read mux; zero when not strobed or unmapped.
  always_comb begin
    reg_rd_data = 32'd0;
    if (reg_rd_en) begin
      case (reg_addr)
        IRQ_REG_ENABLE:    reg_rd_data = 32'(enable_q);
        IRQ_REG_EDGE:      reg_rd_data = 32'(edge_q);
        IRQ_REG_PRIO:      reg_rd_data = prio_rd;
        IRQ_REG_THRESH:    reg_rd_data = thresh_rd;
        IRQ_REG_PENDING:   reg_rd_data = 32'(pending);
        IRQ_REG_ACTIVE_ID: reg_rd_data = {irq_active, 26'd0, active_id_q};
        default:           reg_rd_data = 32'd0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/irq_ctrl.md
# irq_ctrl

Interrupt controller between the peripheral interrupt lines and the core trap unit. It latches up to `NUM_SRC` peripheral requests as edge- or level-sensitive pending bits and applies per-source enable, priority and a global threshold. It presents one registered winner to the trap unit over a request/ack/done handshake and blocks further requests while a source is in service. Software configures it through a CSR-style register port.

## Interface
Parameters:
- `NUM_SRC`, 16: number of interrupt sources, 1..16.
- `ID_BASE`, 16: cause number reported for source 0. Source i reports `ID_BASE + i`.

Ports:
- `clk`, in, 1: core clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `src_irq`, in, `NUM_SRC`: raw interrupt lines, synchronous to `clk`.
- `reg_rd_en`, in, 1: register read strobe.
- `reg_wr_en`, in, 1: register write strobe.
- `reg_addr`, in, 3: register index.
- `reg_wr_data`, in, 32: write data.
- `reg_rd_data`, out, 32: combinational read data. 0 when `!reg_rd_en` or the index is unmapped.
- `irq_req`, out, 1: an interrupt is offered to the trap unit.
- `irq_id`, out, 5: cause number of the offered interrupt.
- `irq_ack`, in, 1: trap unit takes the offered interrupt.
- `irq_done`, in, 1: trap return (mret) completed.
- `done_id`, in, 5: cause number being completed.
- `irq_active`, out, 1: a source is in service.

## Operation
Registers, reset value 0:
- 0 ENABLE: one bit per source.
- 1 EDGE: 1 = edge-sensitive, 0 = level-sensitive.
- 2 PRIO: 2 bits per source, source i at [2i+1:2i].
- 3 THRESH: bits [1:0].
- 4 PENDING: read; write-1-clears edge bits.
- 5 ACTIVE_ID: read-only. Bit 31 = active, [4:0] = id.
- Unused bits and bits at or above `NUM_SRC` read 0.

Pending bits:
- Edge source: pending set on the clock edge where `src_irq[i]=1` and the registered previous sample `src_q[i]=0`.
- Edge source: pending cleared by `irq_ack` when the source is the winner, or by a PENDING write-1.
- Set wins over a simultaneous clear.
- Level source: pending = `src_q[i]`. It is not cleared by ack or by writes.

Eligibility and arbitration:
- A source is eligible when pending & ENABLE & (PRIO > THRESH).
- PRIO 0 therefore never fires.
- Winner is the highest PRIO; ties go to the lowest index.
- The winner is registered every cycle.

State machine:
- IDLE: if a winner exists, go to REQ.
- REQ: `irq_req=1`, `irq_id` = current registered winner. The winner may change to a higher one before ack.
  - Eligibility lost with no winner: go back to IDLE, `irq_req` drops next cycle.
  - `irq_ack`: latch `irq_id` as the active id, go to ACTIVE.
- ACTIVE: `irq_req=0`, `irq_active=1`. Pending bits keep accumulating. No nesting.
  - `irq_done` with `done_id` == active id: go to IDLE.
  - `irq_done` with a mismatched id: ignored.
- `irq_ack` outside REQ is ignored.

Reset mid-operation clears all state, pending bits and registers immediately. Pending interrupts are lost.

## Timing
- Reset values: `irq_req=0`, `irq_id=0`, `irq_active=0`, `reg_rd_data=0`. All registers are 0 and the state is IDLE.
- `src_irq` rises in cycle N: pending set at the end of N, winner registered at the end of N+1, `irq_req` high in N+2.
- Edge case: the same source edge arriving in the ack cycle sets pending again (set wins).
- Ack in cycle M: `irq_req` low and `irq_active` high in M+1.
- Done in cycle D: IDLE in D+1. A waiting winner raises `irq_req` in D+2.
- Register writes take effect at the next edge. Arbitration sees them one cycle later.

## Configuration
- `IRQ_CTRL_PRIO_EN` defined: PRIO and THRESH are implemented as described above.
- `IRQ_CTRL_PRIO_EN` undefined:
  - PRIO and THRESH read 0 and ignore writes.
  - Eligibility is pending & ENABLE.
  - Lowest index wins.
  - The comparator tree is removed.

## Structure
- Add to the `lexington` package:
  - `NUM_IRQ_SRC`.
  - `IRQ_ID_BASE`.
  - Register index constants `IRQ_REG_ENABLE` through `IRQ_REG_ACTIVE_ID`.
  - Enum `irq_state_t` {IDLE, REQ, ACTIVE}.
- One sub-module, `irq_prio_sel`: combinational priority/threshold selector with `NUM_SRC` eligible bits and priorities in, `valid` and index out.

## Test plan
- ENABLE=0x1, EDGE=0x1, PRIO[0]=1, THRESH=0; pulse `src_irq[0]` one cycle:
  - `irq_req=1`, `irq_id=16` two cycles later.
  - Ack: PENDING reads 0, `irq_active=1`.
  - done_id=16: back to IDLE.
- Sources 3 and 5 enabled, both PRIO 2, pending together: `irq_id=19`. Then set PRIO[5]=3: `irq_id` switches to 21 before ack.
- THRESH=2, PRIO[1]=2, level source 1 held high: `irq_req` stays 0. Set THRESH=1: `irq_req=1`.
- In ACTIVE (id 16), assert source 2:
  - No `irq_req` while active.
  - `irq_done` with done_id=17: ignored.
  - done_id=16: `irq_req`, id 18, two cycles later.
- Level source in REQ drops before ack: `irq_req` returns to 0 with no ack needed.
- Assert `rst_n=0` in ACTIVE: all outputs and registers are 0 immediately, asynchronously. Without `IRQ_CTRL_PRIO_EN`, a PRIO write reads back 0.
